// File: rtl/nmr_scan_scheduler_if.sv
// Signal bundle between the scan scheduler, the host register block and the pulse-program FSM.
interface nmr_scan_scheduler_if #(
  parameter int DATABUS_WIDTH  = 32,
  parameter int SCAN_CNT_WIDTH = 16
);
  logic                      cmd_start;
  logic                      cmd_abort;
  logic [SCAN_CNT_WIDTH-1:0] num_scans;
  logic [DATABUS_WIDTH-1:0]  rep_delay;
  logic                      phase_cyc_en;
  logic                      pp_fsmstat;
  logic                      pp_start;
  logic                      pp_phase_cyc;
  logic                      busy;
  logic [SCAN_CNT_WIDTH-1:0] scan_idx;
  logic                      scan_done;
  logic                      done;
  logic                      aborted;
  logic                      err_timeout;

  modport master (
    output cmd_start, cmd_abort, num_scans, rep_delay, phase_cyc_en, pp_fsmstat,
    input  pp_start, pp_phase_cyc, busy, scan_idx, scan_done, done, aborted, err_timeout
  );

  modport slave (
    input  cmd_start, cmd_abort, num_scans, rep_delay, phase_cyc_en, pp_fsmstat,
    output pp_start, pp_phase_cyc, busy, scan_idx, scan_done, done, aborted, err_timeout
  );
endinterface

// File: rtl/nmr_scan_scheduler.sv
// Scan-averaging sequencer: one pulse-program run per scan, T_R gap between scans,
// phase alternation, abort and start-handshake timeout. All outputs are registered.
module nmr_scan_scheduler #(
  parameter int DATABUS_WIDTH  = 32,
  parameter int SCAN_CNT_WIDTH = 16,
  parameter int START_TIMEOUT  = 16
) (
  input logic                 CLK,
  input logic                 RESET,
  nmr_scan_scheduler_if.slave bus
);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_RUN, WAIT_END, REPDLY, FINISH, DRAIN
  } state_t;

  state_t                    state, state_n;
  logic [SCAN_CNT_WIDTH-1:0] num_q;
  logic [DATABUS_WIDTH-1:0]  rep_q;
  logic                      phase_en_q;
  logic [SCAN_CNT_WIDTH-1:0] scan_idx_q, idx_n;
  logic [DATABUS_WIDTH-1:0]  rep_cnt_q, rep_cnt_n;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_n;
  logic                      accept, scan_end, timeout_hit;
  logic                      pp_start_q, pp_phase_q, busy_q;
  logic                      scan_done_q, done_q, aborted_q, err_q;

  always_comb begin
    state_n     = state;
    idx_n       = scan_idx_q;
    rep_cnt_n   = rep_cnt_q;
    to_cnt_n    = to_cnt_q;
    accept      = 1'b0;
    scan_end    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_start) begin
          accept  = 1'b1;
          idx_n   = '0;
          state_n = (bus.num_scans == '0) ? FINISH : ARM;
        end
      end
      ARM: begin
        to_cnt_n = '0;
        state_n  = bus.cmd_abort ? DRAIN : WAIT_RUN;
      end
      WAIT_RUN: begin
        if (bus.cmd_abort) begin
          state_n = DRAIN;
        end else if (bus.pp_fsmstat) begin
          state_n = WAIT_END;
        end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = DRAIN;
        end else begin
          to_cnt_n = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_END: begin
        // A scan that has already ended is still reported even when abort arrives with it.
        if (!bus.pp_fsmstat) begin
          scan_end = 1'b1;
          if (bus.cmd_abort) begin
            state_n = DRAIN;
          end else if (scan_idx_q == num_q - SCAN_CNT_WIDTH'(1)) begin
            state_n = FINISH;
          end else begin
            idx_n     = scan_idx_q + SCAN_CNT_WIDTH'(1);
            rep_cnt_n = rep_q;
            state_n   = (rep_q == '0) ? ARM : REPDLY;
          end
        end else if (bus.cmd_abort) begin
          state_n = DRAIN;
        end
      end
      REPDLY: begin
        if (bus.cmd_abort) begin
          state_n = DRAIN;
        end else if (rep_cnt_q <= DATABUS_WIDTH'(1)) begin
          state_n = ARM;
        end else begin
          rep_cnt_n = rep_cnt_q - DATABUS_WIDTH'(1);
        end
      end
      FINISH: state_n = IDLE;
      DRAIN: begin
        if (!bus.pp_fsmstat) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      num_q       <= '0;
      rep_q       <= '0;
      phase_en_q  <= 1'b0;
      scan_idx_q  <= '0;
      rep_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pp_start_q  <= 1'b0;
      pp_phase_q  <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state      <= state_n;
      scan_idx_q <= idx_n;
      rep_cnt_q  <= rep_cnt_n;
      to_cnt_q   <= to_cnt_n;
      if (accept) begin
        num_q      <= bus.num_scans;
        rep_q      <= bus.rep_delay;
        phase_en_q <= bus.phase_cyc_en;
      end
      // Phase select is updated on entry to ARM, one cycle ahead of the PP_START rise.
      if (state_n == ARM) pp_phase_q <= phase_en_q & idx_n[0];
      pp_start_q  <= (state_n == WAIT_RUN);
      busy_q      <= (state_n != IDLE);
      scan_done_q <= scan_end;
      done_q      <= (state == FINISH);
      aborted_q   <= (state == DRAIN) && !bus.pp_fsmstat;
      if (accept)           err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign bus.pp_start     = pp_start_q;
  assign bus.pp_phase_cyc = pp_phase_q;
  assign bus.busy         = busy_q;
  assign bus.scan_idx     = scan_idx_q;
  assign bus.scan_done    = scan_done_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_nmr_scan_scheduler.sv
// Scoreboard bench for nmr_scan_scheduler: stimulus queues expected events, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_nmr_scan_scheduler;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int TO = 16;
  localparam int K_START = 0;
  localparam int K_SDONE = 1;
  localparam int K_DONE  = 2;
  localparam int K_ABORT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // pulse-program model controls and observations
  int pp_respond = 1;
  int pp_hold    = 50;
  int fall_cyc   = -1000;

  // monitor bookkeeping
  int rise_cyc = 0, busy_cyc = 0, last_sd = 0, last_len = 0;

  typedef struct {
    int kind; int idx; int phase; int gap; int sd; int len; int err; int blen;
  } exp_t;
  exp_t exp_q[$];

  nmr_scan_scheduler_if #(.DATABUS_WIDTH(DW), .SCAN_CNT_WIDTH(SW)) bus ();

  nmr_scan_scheduler #(
    .DATABUS_WIDTH(DW), .SCAN_CNT_WIDTH(SW), .START_TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int idx, input int phase, input int gap,
                      input int sd, input int len, input int err, input int blen);
    exp_t e;
    e.kind = kind; e.idx = idx; e.phase = phase; e.gap = gap;
    e.sd = sd; e.len = len; e.err = err; e.blen = blen;
    exp_q.push_back(e);
  endtask

  task automatic exp_start(input int idx, input int phase, input int gap);
    push(K_START, idx, phase, gap, -1, -1, -1, -1);
  endtask
  task automatic exp_sdone();
    push(K_SDONE, -1, -1, -1, -1, -1, -1, -1);
  endtask
  task automatic exp_done(input int idx, input int sd, input int blen);
    push(K_DONE, idx, -1, -1, sd, -1, 0, blen);
  endtask
  task automatic exp_abort(input int idx, input int gap, input int len, input int err);
    push(K_ABORT, idx, -1, gap, -1, len, err, -1);
  endtask

  task automatic on_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (e.idx   >= 0) chk("scan_idx", bus.scan_idx, e.idx);
    if (e.phase >= 0) chk("pp_phase_cyc", bus.pp_phase_cyc, e.phase);
    if (e.gap   >= 0) chk("gap_from_fsmstat_fall", cyc - fall_cyc, e.gap);
    if (e.sd    >= 0) chk("done_after_scan_done", cyc - last_sd, e.sd);
    if (e.len   >= 0) chk("pp_start_width", last_len, e.len);
    if (e.err   >= 0) chk("err_timeout", bus.err_timeout, e.err);
    if (e.blen  >= 0) chk("busy_width", cyc - busy_cyc, e.blen);
    if (kind == K_DONE || kind == K_ABORT) chk("busy_at_end", bus.busy, 0);
    if (kind == K_SDONE) chk("done_with_scan_done", bus.done | bus.aborted, 0);
  endtask

  initial begin : monitor
    logic prev_start, prev_busy;
    prev_start = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pp_start && !prev_start) begin
        rise_cyc = cyc;
        on_event(K_START);
      end
      if (!bus.pp_start && prev_start) last_len = cyc - rise_cyc;
      if (bus.busy && !prev_busy) busy_cyc = cyc;
      if (bus.scan_done) begin
        on_event(K_SDONE);
        last_sd = cyc;
      end
      if (bus.done)    on_event(K_DONE);
      if (bus.aborted) on_event(K_ABORT);
      prev_start = bus.pp_start;
      prev_busy  = bus.busy;
    end
  end

  // Pulse program: FSMSTAT rises 2 cycles after PP_START is seen and stays high pp_hold cycles.
  initial begin : pp_model
    int dly, hold;
    dly = 0;
    hold = 0;
    bus.pp_fsmstat = 1'b0;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          bus.pp_fsmstat = 1'b0;
          fall_cyc = cyc;
        end
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.pp_fsmstat = 1'b1;
          hold = pp_hold;
        end
      end else if (bus.pp_start && !bus.pp_fsmstat && pp_respond != 0) begin
        dly = 2;
      end
    end
  end

  task automatic run(input int ns, input int rd, input bit en);
    @(negedge clk);
    bus.num_scans    = SW'(ns);
    bus.rep_delay    = DW'(rd);
    bus.phase_cyc_en = en;
    bus.cmd_start    = 1'b1;
    @(negedge clk);
    bus.cmd_start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.busy) && n < budget);
    checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL %s_completion: pending=%0d busy=%0d after %0d cycles, required 0 and 0",
               name, exp_q.size(), bus.busy, n);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pp_start"}, bus.pp_start, 0);
    chk({tag, "_pp_phase_cyc"}, bus.pp_phase_cyc, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_scan_idx"}, bus.scan_idx, 0);
    chk({tag, "_scan_done"}, bus.scan_done, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_aborted"}, bus.aborted, 0);
    chk({tag, "_err_timeout"}, bus.err_timeout, 0);
  endtask

  initial begin : stim
    int n;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.num_scans = '0;
    bus.rep_delay = '0;
    bus.phase_cyc_en = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // three scans, T_R = 10, phase cycling on
    exp_start(0, 0, -1); exp_sdone();
    exp_start(1, 1, 12); exp_sdone();
    exp_start(2, 0, 12); exp_sdone();
    exp_done(2, 1, -1);
    run(3, 10, 1);
    wait_idle(600, "three_scans");

    // zero scans: DONE with no pulse-program start, BUSY for one cycle
    exp_done(0, -1, 1);
    run(0, 7, 1);
    wait_idle(20, "zero_scans");

    // two scans, no repetition delay, phase cycling off
    exp_start(0, 0, -1); exp_sdone();
    exp_start(1, 0, 2);  exp_sdone();
    exp_done(1, 1, -1);
    run(2, 0, 0);
    wait_idle(400, "no_delay");

    // pulse program never answers: timeout, sticky error, aborted completion
    pp_respond = 0;
    exp_start(0, 0, -1);
    exp_abort(0, -1, TO, 1);
    run(1, 5, 1);
    wait_idle(200, "timeout");
    chk("err_sticky_in_idle", bus.err_timeout, 1);
    pp_respond = 1;

    // abort during scan 2 of 5 while the pulse program is running
    exp_start(0, 0, -1); exp_sdone();
    exp_start(1, 1, 5);
    run(5, 3, 1);
    chk("err_cleared_by_start", bus.err_timeout, 0);
    n = 0;
    while (!(bus.scan_idx == 1 && bus.pp_fsmstat) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_scan2_running", (bus.scan_idx == 1 && bus.pp_fsmstat) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    exp_abort(1, 1, -1, 0);
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_abort = 1'b0;
    wait_idle(200, "abort");

    // asynchronous reset during the repetition delay, then a fresh experiment
    exp_start(0, 0, -1); exp_sdone();
    run(3, 40, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("first_scan_seen", exp_q.size(), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    chk("pre_reset_scan_idx", bus.scan_idx, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_start(0, 0, -1); exp_sdone();
    exp_start(1, 1, 2);  exp_sdone();
    exp_done(1, 1, -1);
    run(2, 0, 1);
    wait_idle(400, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nmr_scan_scheduler.md
Name: nmr_scan_scheduler

Overview:
Scan-averaging sequencer that sits above the NMR pulse-program FSM.
- Fires one pulse-program run per scan and waits for each run to finish.
- Inserts a repetition (T_R) delay between scans and alternates the phase-cycling select on every scan.
- Reports per-scan and end-of-experiment status to the host register interface.
- Supports abort and a start-handshake timeout.

Parameters:
DATABUS_WIDTH, 32, width of REP_DELAY and of the internal repetition counter
SCAN_CNT_WIDTH, 16, width of NUM_SCANS and SCAN_IDX
START_TIMEOUT, 16, max cycles allowed from PP_START assertion to PP_FSMSTAT high (must be ≥4)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
CMD_START  in  1  host request to begin an experiment; level, sampled in IDLE only
CMD_ABORT  in  1  host abort; level, sampled in every non-IDLE state
NUM_SCANS  in  SCAN_CNT_WIDTH  number of scans; latched on accepted CMD_START
REP_DELAY  in  DATABUS_WIDTH  idle cycles between scans; latched on accepted CMD_START
PHASE_CYC_EN  in  1  enables per-scan phase alternation; latched on accepted CMD_START
PP_FSMSTAT  in  1  pulse-program busy flag
PP_START  out  1  start request to the pulse program
PP_PHASE_CYC  out  1  phase-cycle select to the pulse program
BUSY  out  1  high from the accepted CMD_START until return to IDLE
SCAN_IDX  out  SCAN_CNT_WIDTH  index of the current scan, 0-based
SCAN_DONE  out  1  one-cycle pulse when a scan's PP_FSMSTAT falls
DONE  out  1  one-cycle pulse on normal completion
ABORTED  out  1  one-cycle pulse on completion via abort
ERR_TIMEOUT  out  1  sticky; set on start timeout, cleared by the next accepted CMD_START

Behaviour:
- Reset: all outputs 0; state IDLE; latched parameters and counters 0. Asserting RESET mid-experiment drops PP_START immediately (async); the pulse program has its own reset.
- IDLE:
  - CMD_START=1 → latch NUM_SCANS, REP_DELAY and PHASE_CYC_EN; clear ERR_TIMEOUT; SCAN_IDX=0; BUSY=1 next cycle.
  - If the latched NUM_SCANS==0 → go to FINISH (DONE pulse, no PP_START).
  - Otherwise → go to ARM.
- ARM:
  - PP_PHASE_CYC = PHASE_CYC_EN & SCAN_IDX[0], registered in this state.
  - PP_PHASE_CYC changes only in ARM, which guarantees it is stable before PP_START rises.
  - Next cycle: PP_START=1, timeout counter cleared, → WAIT_RUN.
- WAIT_RUN:
  - PP_START held high until PP_FSMSTAT=1 is sampled; then PP_START=0 and → WAIT_END.
  - If the timeout counter reaches START_TIMEOUT first: PP_START=0, ERR_TIMEOUT=1 → DRAIN.
- WAIT_END:
  - Wait for PP_FSMSTAT=0, then pulse SCAN_DONE once.
  - If SCAN_IDX==NUM_SCANS-1 → FINISH.
  - Else SCAN_IDX+1, repetition counter loaded with REP_DELAY → REPDLY. REP_DELAY==0 → go directly to ARM.
- REPDLY:
  - Count down one per cycle; at 1 → ARM.
  - The gap from PP_FSMSTAT low to the next PP_START rise is exactly REP_DELAY+2 cycles. With REP_DELAY=0 the gap is 2 cycles.
- FINISH: DONE=1 for one cycle, BUSY=0 → IDLE.
- CMD_ABORT:
  - From ARM, WAIT_RUN, WAIT_END or REPDLY → PP_START=0 next cycle → DRAIN.
  - A running scan is never truncated.
  - Abort has priority over every same-cycle transition, except that an abort with PP_FSMSTAT already 0 in WAIT_END still emits SCAN_DONE.
- DRAIN: wait until PP_FSMSTAT=0, then ABORTED=1 for one cycle, BUSY=0 → IDLE. SCAN_IDX holds its last value.
- Boundaries and counters:
  - DONE, ABORTED and SCAN_DONE are never asserted together, with one exception: in FINISH, the final SCAN_DONE precedes DONE by exactly 1 cycle.
  - SCAN_IDX wraps only if NUM_SCANS equals 2^SCAN_CNT_WIDTH, which is unrepresentable, so it never wraps.
  - The repetition counter is unsigned DATABUS_WIDTH bits, with no saturation needed.
- Input handling:
  - CMD_START while BUSY is ignored.
  - A CMD_START held high across a return to IDLE restarts the experiment; the host must deassert it.

Test Plan:
- NUM_SCANS=3, REP_DELAY=10, PHASE_CYC_EN=1, PP model raises FSMSTAT 2 cycles after START and holds it 50 cycles → 3 PP_START pulses; PP_PHASE_CYC=0,1,0; 3 SCAN_DONE pulses; inter-scan gap 12 cycles; DONE 1 cycle after the 3rd SCAN_DONE.
- NUM_SCANS=0 → DONE within 2 cycles of CMD_START; PP_START never asserted; BUSY high for 1 cycle.
- NUM_SCANS=2, REP_DELAY=0, PHASE_CYC_EN=0 → PP_PHASE_CYC stays 0; gap from FSMSTAT fall to the next PP_START is 2 cycles.
- PP model never raises FSMSTAT, START_TIMEOUT=16 → PP_START low 16 cycles after rising; ERR_TIMEOUT=1; ABORTED pulse; BUSY=0. The next CMD_START clears ERR_TIMEOUT.
- CMD_ABORT mid-scan 2 of 5 (FSMSTAT high) → no further PP_START; ABORTED only after FSMSTAT falls; SCAN_IDX=1.
- RESET asserted in REPDLY → all outputs 0 asynchronously; after release, CMD_START runs a fresh experiment from SCAN_IDX=0.
